// File: rtl/circle_tracer_pkg.sv
// Shared widths, FSM state codes and step-direction encoding for the circle tracer.
// Every other circle_tracer file imports this package.
package circle_tracer_pkg;

  localparam int RW_DEF = 8;   // radius width
  localparam int CW_DEF = 16;  // signed coordinate width
  localparam int EW_DEF = 20;  // signed error width, at least 2*RW+4

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } step_dir_e;

  function automatic logic signed [1:0] dir_delta(input step_dir_e d);
    return (d == DIR_NEG) ? -2'sd1 : 2'sd1;
  endfunction

endpackage

// File: rtl/circle_tracer_if.sv
// Command and point-stream handshake bundle between the command source, the tracer
// and the frame writer. The master side issues commands and consumes points.
interface circle_tracer_if
  import circle_tracer_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [RW-1:0]        cmd_r;
  logic signed [CW-1:0] cmd_cx;
  logic signed [CW-1:0] cmd_cy;

  logic                 pt_valid;
  logic                 pt_ready;
  logic signed [CW-1:0] pt_x;
  logic signed [CW-1:0] pt_y;
  logic                 pt_last;

  modport master (
    output cmd_valid, cmd_r, cmd_cx, cmd_cy, pt_ready,
    input  cmd_ready, pt_valid, pt_x, pt_y, pt_last
  );

  modport slave (
    input  cmd_valid, cmd_r, cmd_cx, cmd_cy, pt_ready,
    output cmd_ready, pt_valid, pt_x, pt_y, pt_last
  );

endinterface

// File: rtl/circle_tracer_step.sv
// Combinational next-point chooser: scores three neighbour candidates by |x^2+y^2-R^2|
// and flags when the chosen successor is the start point (R,0).
module circle_tracer_step
  import circle_tracer_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic signed [RW+1:0] x,
  input  logic signed [RW+1:0] y,
  input  logic [RW-1:0]        r,
  output logic signed [RW+1:0] nx,
  output logic signed [RW+1:0] ny,
  output logic                 close
);

  localparam int XW = RW + 2;
  typedef logic signed [XW-1:0] coord_t;
  typedef logic signed [EW-1:0] err_t;

  function automatic err_t err_of(input coord_t px, input coord_t py, input err_t rr);
    err_t ex;
    err_t ey;
    ex = EW'(px);
    ey = EW'(py);
    return ex * ex + ey * ey - rr * rr;
  endfunction

  function automatic logic [EW-1:0] mag(input err_t e);
    return (e < 0) ? $unsigned(-e) : $unsigned(e);
  endfunction

  step_dir_e     sx, sy;
  coord_t        dx, dy, r_ext;
  err_t          r_err;
  logic [EW-1:0] mag_a, mag_b, mag_c;

  always_comb begin
    sx    = (y > 0 || (y == 0 && x > 0)) ? DIR_NEG : DIR_POS;
    sy    = (x > 0 || (x == 0 && y < 0)) ? DIR_POS : DIR_NEG;
    dx    = XW'(dir_delta(sx));
    dy    = XW'(dir_delta(sy));
    r_ext = $signed({2'b00, r});
    r_err = EW'(r_ext);
    mag_a = mag(err_of(x,      y + dy, r_err));
    mag_b = mag(err_of(x + dx, y,      r_err));
    mag_c = mag(err_of(x + dx, y + dy, r_err));
    // Ties prefer the diagonal, then the y step, then the x step.
    if (mag_c <= mag_a && mag_c <= mag_b) begin
      nx = x + dx;
      ny = y + dy;
    end else if (mag_a <= mag_b) begin
      nx = x;
      ny = y + dy;
    end else begin
      nx = x + dx;
      ny = y;
    end
    close = (nx == r_ext) && (ny == '0);
  end

endmodule

// File: rtl/circle_tracer.sv
// Walks the lattice circle of radius R about (cx,cy) counter-clockwise, one point per
// clock over a valid/ready stream; internal (x,y) runs one point ahead of the output regs.
module circle_tracer
  import circle_tracer_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic           gclock,
  input  logic           rst_n,
  circle_tracer_if.slave bus,
  output logic           busy
);

  localparam int XW = RW + 2;
  localparam int NW = RW + 4;

  logic [0:0]           state_q, state_d;
  logic [RW-1:0]        r_q, r_d;
  logic signed [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [NW-1:0]        cnt_q, cnt_d;
  logic                 pt_valid_q, pt_valid_d, pt_last_q, pt_last_d;
  logic signed [CW-1:0] pt_x_q, pt_x_d, pt_y_q, pt_y_d;

  logic                 idle;
  logic signed [XW-1:0] r_cmd_ext, st_x, st_y, nx, ny;
  logic [RW-1:0]        st_r;
  logic                 close;
  logic [NW-1:0]        guard_lim;

  assign idle      = (state_q == ST_IDLE);
  assign r_cmd_ext = $signed({2'b00, bus.cmd_r});
  assign guard_lim = {1'b0, r_q, 3'b000} + NW'(8);

  // In IDLE the step unit pre-computes the successor of the start point of the pending command.
  assign st_x = idle ? r_cmd_ext : x_q;
  assign st_y = idle ? '0 : y_q;
  assign st_r = idle ? bus.cmd_r : r_q;

  circle_tracer_step #(.RW(RW), .EW(EW)) u_step (
    .x     (st_x),
    .y     (st_y),
    .r     (st_r),
    .nx    (nx),
    .ny    (ny),
    .close (close)
  );

  always_comb begin
    // NOTE: every _d starts from its held value so no branch can infer a latch.
    state_d    = state_q;
    r_d        = r_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    pt_valid_d = pt_valid_q;
    pt_last_d  = pt_last_q;
    pt_x_d     = pt_x_q;
    pt_y_d     = pt_y_q;
    if (idle) begin
      if (bus.cmd_valid) begin
        state_d    = ST_RUN;
        r_d        = bus.cmd_r;
        cx_d       = bus.cmd_cx;
        cy_d       = bus.cmd_cy;
        x_d        = nx;
        y_d        = ny;
        cnt_d      = NW'(1);
        pt_valid_d = 1'b1;
        pt_x_d     = bus.cmd_cx + CW'(r_cmd_ext);
        pt_y_d     = bus.cmd_cy;
        pt_last_d  = (bus.cmd_r == '0) || close;
      end
    end else if (pt_valid_q && bus.pt_ready) begin
      if (pt_last_q) begin
        state_d    = ST_IDLE;
        pt_valid_d = 1'b0;
        pt_last_d  = 1'b0;
      end else begin
        x_d       = nx;
        y_d       = ny;
        cnt_d     = cnt_q + 1'b1;
        pt_x_d    = cx_q + CW'(x_q);
        pt_y_d    = cy_q + CW'(y_q);
        // The point-count guard ends a walk that never closes.
        pt_last_d = close || (cnt_d >= guard_lim);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge gclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      r_q        <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      pt_valid_q <= 1'b0;
      pt_last_q  <= 1'b0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      pt_valid_q <= pt_valid_d;
      pt_last_q  <= pt_last_d;
      pt_x_q     <= pt_x_d;
      pt_y_q     <= pt_y_d;
    end
  end

  assign bus.cmd_ready = idle;
  assign bus.pt_valid  = pt_valid_q;
  assign bus.pt_last   = pt_last_q;
  assign bus.pt_x      = pt_x_q;
  assign bus.pt_y      = pt_y_q;
  assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_circle_tracer.sv
// Directed bench for circle_tracer: hand-derived point sequences, stall, back-to-back
// command, R=20 geometry properties and mid-circle reset.
module tb_circle_tracer;
  import circle_tracer_pkg::*;

  logic gclock = 1'b0;
  logic rst_n;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  circle_tracer_if #(.RW(RW_DEF), .CW(CW_DEF)) bus ();

  circle_tracer #(.RW(RW_DEF), .CW(CW_DEF), .EW(EW_DEF)) dut (
    .gclock (gclock),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .busy   (busy)
  );

  always #5 gclock = ~gclock;

  int r3x [16] = '{3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1, 0, 1, 2, 3};
  int r3y [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pt(input string tag, input int ex, input int ey, input int el);
    check({tag, ".valid"}, 32'(bus.pt_valid), 1);
    check({tag, ".x"}, 32'(bus.pt_x), ex);
    check({tag, ".y"}, 32'(bus.pt_y), ey);
    check({tag, ".last"}, 32'(bus.pt_last), el);
  endtask

  task automatic send_cmd(input int r, input int cx, input int cy);
    check("cmd.ready_before", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_r     = RW_DEF'(r);
    bus.cmd_cx    = CW_DEF'(cx);
    bus.cmd_cy    = CW_DEF'(cy);
    @(negedge gclock);
    bus.cmd_valid = 1'b0;
  endtask

  int  px[$];
  int  py[$];
  int  cx_rel, cy_rel, e, ddx, ddy, dups;
  bit  done;

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_r     = '0;
    bus.cmd_cx    = '0;
    bus.cmd_cy    = '0;
    bus.pt_ready  = 1'b0;
    #1;
    check("rst.cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst.pt_valid", 32'(bus.pt_valid), 0);
    check("rst.pt_last", 32'(bus.pt_last), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.pt_x", 32'(bus.pt_x), 0);
    check("rst.pt_y", 32'(bus.pt_y), 0);
    @(negedge gclock);
    rst_n = 1'b1;
    @(negedge gclock);

    // R=1 about the origin, consumer always ready
    bus.pt_ready = 1'b1;
    send_cmd(1, 0, 0);
    check("r1.busy", 32'(busy), 1);
    check("r1.cmd_ready", 32'(bus.cmd_ready), 0);
    expect_pt("r1.p0", 1, 0, 0);  @(negedge gclock);
    expect_pt("r1.p1", 0, 1, 0);  @(negedge gclock);
    expect_pt("r1.p2", -1, 0, 0); @(negedge gclock);
    expect_pt("r1.p3", 0, -1, 1); @(negedge gclock);
    check("r1.end_valid", 32'(bus.pt_valid), 0);
    check("r1.end_ready", 32'(bus.cmd_ready), 1);
    check("r1.end_busy", 32'(busy), 0);

    // R=0 emits only the centre
    send_cmd(0, 5, -3);
    expect_pt("r0.p0", 5, -3, 1); @(negedge gclock);
    check("r0.end_valid", 32'(bus.pt_valid), 0);
    check("r0.end_ready", 32'(bus.cmd_ready), 1);

    // R=1 with a 3-clock stall on the second point
    send_cmd(1, 10, 20);
    expect_pt("st.p0", 11, 20, 0); @(negedge gclock);
    bus.pt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_pt($sformatf("st.hold%0d", i), 10, 21, 0);
      @(negedge gclock);
    end
    bus.pt_ready = 1'b1;
    expect_pt("st.p1", 10, 21, 0); @(negedge gclock);
    expect_pt("st.p2", 9, 20, 0);  @(negedge gclock);
    expect_pt("st.p3", 10, 19, 1); @(negedge gclock);
    check("st.end_valid", 32'(bus.pt_valid), 0);

    // R=3 with the next command held pending throughout
    bus.cmd_valid = 1'b1;
    bus.cmd_r     = RW_DEF'(3);
    bus.cmd_cx    = '0;
    bus.cmd_cy    = '0;
    @(negedge gclock);
    bus.cmd_r  = RW_DEF'(1);
    bus.cmd_cx = -CW_DEF'(7);
    bus.cmd_cy = CW_DEF'(7);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("r3.cmd_ready%0d", i), 32'(bus.cmd_ready), 0);
      expect_pt($sformatf("r3.p%0d", i), r3x[i], r3y[i], (i == 15) ? 1 : 0);
      @(negedge gclock);
    end
    check("r3.pend_ready", 32'(bus.cmd_ready), 1);
    check("r3.pend_valid", 32'(bus.pt_valid), 0);
    @(negedge gclock);
    bus.cmd_valid = 1'b0;
    expect_pt("q.p0", -6, 7, 0); @(negedge gclock);
    expect_pt("q.p1", -7, 8, 0); @(negedge gclock);
    expect_pt("q.p2", -8, 7, 0); @(negedge gclock);
    expect_pt("q.p3", -7, 6, 1); @(negedge gclock);
    check("q.end_valid", 32'(bus.pt_valid), 0);

    // R=20 about (100,100): geometric properties of the whole walk
    send_cmd(20, 100, 100);
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (bus.pt_valid) begin
        cx_rel = int'(bus.pt_x) - 100;
        cy_rel = int'(bus.pt_y) - 100;
        e = cx_rel * cx_rel + cy_rel * cy_rel - 400;
        check($sformatf("r20.err_ok(%0d,%0d)", cx_rel, cy_rel), 32'(e <= 20 && e >= -20), 1);
        if (px.size() > 0) begin
          ddx = cx_rel - px[$];
          ddy = cy_rel - py[$];
          check($sformatf("r20.adj(%0d,%0d)", cx_rel, cy_rel),
                32'(ddx >= -1 && ddx <= 1 && ddy >= -1 && ddy <= 1 && !(ddx == 0 && ddy == 0)), 1);
        end
        px.push_back(cx_rel);
        py.push_back(cy_rel);
        done = bus.pt_last;
      end
      @(negedge gclock);
    end
    check("r20.closed", 32'(done), 1);
    check("r20.first_x", (px.size() > 0) ? px[0] : -999, 20);
    check("r20.first_y", (py.size() > 0) ? py[0] : -999, 0);
    dups = 0;
    for (int i = 0; i < px.size(); i++)
      for (int j = i + 1; j < px.size(); j++)
        if (px[i] == px[j] && py[i] == py[j]) dups++;
    check("r20.dups", dups, 0);
    if (px.size() > 0) begin
      ddx = 20 - px[$];
      ddy = 0 - py[$];
    end
    check("r20.wraps_to_start", 32'(px.size() > 0 && ddx >= -1 && ddx <= 1 && ddy >= -1 && ddy <= 1
                                    && !(ddx == 0 && ddy == 0)), 1);
    check("r20.no_guard", 32'(px.size() < 168), 1);
    check("r20.end_valid", 32'(bus.pt_valid), 0);

    // R=5 interrupted by reset on its third point
    send_cmd(5, 0, 0);
    expect_pt("r5.p0", 5, 0, 0); @(negedge gclock);
    expect_pt("r5.p1", 5, 1, 0); @(negedge gclock);
    expect_pt("r5.p2", 5, 2, 0);
    #2 rst_n = 1'b0;
    #1;
    check("r5.rst_valid", 32'(bus.pt_valid), 0);
    check("r5.rst_ready", 32'(bus.cmd_ready), 1);
    check("r5.rst_busy", 32'(busy), 0);
    check("r5.rst_x", 32'(bus.pt_x), 0);
    check("r5.rst_last", 32'(bus.pt_last), 0);
    @(negedge gclock);
    rst_n = 1'b1;
    @(negedge gclock);
    send_cmd(1, 2, 2);
    expect_pt("post.p0", 3, 2, 0); @(negedge gclock);
    expect_pt("post.p1", 2, 3, 0); @(negedge gclock);
    expect_pt("post.p2", 1, 2, 0); @(negedge gclock);
    expect_pt("post.p3", 2, 1, 1); @(negedge gclock);
    check("post.end_valid", 32'(bus.pt_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
